// File: rtl/cfi_shadow_stack_pkg.sv
// rtl/cfi_shadow_stack_pkg.sv - shared types and defaults for the CFI shadow stack
// Contents: cfi_ss_state_e (RUN/ALARM), default DEPTH and NR_CTX.
// Optional feature macro used by the bundle: CFI_SS_OVF_WRAP_EN.
package cfi_shadow_stack_pkg;

    typedef enum logic [0:0] {
        CFI_SS_RUN   = 1'b0,
        CFI_SS_ALARM = 1'b1
    } cfi_ss_state_e;

    localparam int CFI_SS_DEFAULT_DEPTH  = 16;
    localparam int CFI_SS_DEFAULT_NR_CTX = 2;

endpackage

// File: rtl/cfi_shadow_stack_if.sv
// rtl/cfi_shadow_stack_if.sv - committed control-transfer event channel
// Signals: valid_i, is_call_i, is_ret_i, ctx_i, link_addr_i, target_i (producer -> stack),
//          ready_o (stack -> producer). master = event producer, slave = shadow stack.
interface cfi_shadow_stack_if #(
    parameter int ADDR_W = 32,
    parameter int CTX_W  = 1
);
    logic              valid_i;
    logic              is_call_i;
    logic              is_ret_i;
    logic [CTX_W-1:0]  ctx_i;
    logic [ADDR_W-1:0] link_addr_i;
    logic [ADDR_W-1:0] target_i;
    logic              ready_o;

    modport master (
        output valid_i, is_call_i, is_ret_i, ctx_i, link_addr_i, target_i,
        input  ready_o
    );

    modport slave (
        input  valid_i, is_call_i, is_ret_i, ctx_i, link_addr_i, target_i,
        output ready_o
    );
endinterface

// File: rtl/cfi_ss_lifo.sv
// rtl/cfi_ss_lifo.sv - one circular LIFO of ADDR_W x DEPTH return addresses
// Ports: clk_i, rst_ni (async, active-low), flush_i (empty the stack),
//        push_i/data_i (write), pop_i (remove top), top_o (current top), count_o (occupancy).
// A pop on an empty stack is ignored. A push when full (and not popping) overwrites the
// oldest entry and keeps occupancy at DEPTH; the caller decides whether that is allowed.
module cfi_ss_lifo
    import cfi_shadow_stack_pkg::*;
#(
    parameter int DEPTH  = CFI_SS_DEFAULT_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [ADDR_W-1:0]        data_i,
    output logic [ADDR_W-1:0]        top_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     ptr_q, ptr_d, wr_addr;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_pop, full;

    assign do_pop = pop_i && (cnt_q != '0);
    assign full   = (cnt_q == CW'(DEPTH));

    // ptr_q is the slot the next push writes; the top lives one below it.
    // When full, ptr_q also addresses the oldest entry, so a wrapping push overwrites it.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_addr = ptr_q;
        if (do_pop && push_i) begin
            // pop-then-push collapses into replacing the top in place
            wr_addr = ptr_q - AW'(1);
        end else if (do_pop) begin
            ptr_d = ptr_q - AW'(1);
            cnt_d = cnt_q - CW'(1);
        end else if (push_i) begin
            ptr_d = ptr_q + AW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents are only meaningful below the occupancy, so the array needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_addr] <= data_i;
        end
    end

    assign top_o   = mem_q[ptr_q - AW'(1)];
    assign count_o = cnt_q;

endmodule

// File: rtl/cfi_shadow_stack.sv
// rtl/cfi_shadow_stack.sv - per-context return-address shadow stack with RUN/ALARM FSM
// Ports: clk_i, rst_ni (async, active-low), ev (event channel, slave), enforce_i, clear_i,
//        violation_o, viol_addr_o, count_o (occupancy of stack ev.ctx_i), mismatch_cnt_o.
// Macro CFI_SS_OVF_WRAP_EN: defined -> push to a full stack overwrites the oldest entry;
//        undefined -> push to a full stack alarms (enforce) or is dropped and counted.
module cfi_shadow_stack
    import cfi_shadow_stack_pkg::*;
#(
    parameter int DEPTH  = CFI_SS_DEFAULT_DEPTH,
    parameter int ADDR_W = 32,
    parameter int NR_CTX = CFI_SS_DEFAULT_NR_CTX
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    cfi_shadow_stack_if.slave      ev,
    input  logic                   enforce_i,
    input  logic                   clear_i,
    output logic                   violation_o,
    output logic [ADDR_W-1:0]      viol_addr_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [15:0]            mismatch_cnt_o
);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CTX_W = (NR_CTX > 1) ? $clog2(NR_CTX) : 1;

    cfi_ss_state_e     state_q, state_d;
    logic [ADDR_W-1:0] tops   [NR_CTX];
    logic [CW-1:0]     counts [NR_CTX];
    logic [ADDR_W-1:0] viol_addr_q;
    logic [15:0]       mm_cnt_q;

    logic [ADDR_W-1:0] sel_top;
    logic [CW-1:0]     sel_cnt;
    logic do_call, do_ret, sel_empty, sel_full, room, ret_bad, ovf_bad, call_ok;
    logic alarm, mm_inc, pop_en, push_en, flush;

    assign sel_top   = tops[ev.ctx_i];
    assign sel_cnt   = counts[ev.ctx_i];
    assign sel_empty = (sel_cnt == '0);
    assign sel_full  = (sel_cnt == CW'(DEPTH));

    assign do_call = (state_q == CFI_SS_RUN) && ev.valid_i && ev.is_call_i;
    assign do_ret  = (state_q == CFI_SS_RUN) && ev.valid_i && ev.is_ret_i;

    // Return is checked against the pre-push top; an empty stack is always a violation.
    assign ret_bad = do_ret && (sel_empty || (sel_top != ev.target_i));
    // A same-event pop frees a slot before the push lands.
    assign room    = !sel_full || (do_ret && !sel_empty);

`ifdef CFI_SS_OVF_WRAP_EN
    assign ovf_bad = 1'b0;
    assign call_ok = do_call;
`else
    assign ovf_bad = do_call && !room;
    assign call_ok = do_call && room;
`endif

    assign alarm  = enforce_i && (ret_bad || ovf_bad);
    assign mm_inc = !enforce_i && (ret_bad || ovf_bad);
    // The alarming event leaves the stack untouched, matching the frozen ALARM view.
    assign pop_en  = do_ret && !alarm;
    assign push_en = call_ok && !alarm;
    assign flush   = (state_q == CFI_SS_ALARM) && clear_i;

    for (genvar g = 0; g < NR_CTX; g++) begin : g_ctx
        cfi_ss_lifo #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_lifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush),
            .push_i  (push_en && (ev.ctx_i == CTX_W'(g))),
            .pop_i   (pop_en && (ev.ctx_i == CTX_W'(g))),
            .data_i  (ev.link_addr_i),
            .top_o   (tops[g]),
            .count_o (counts[g])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CFI_SS_RUN:   if (alarm)   state_d = CFI_SS_ALARM;
            CFI_SS_ALARM: if (clear_i) state_d = CFI_SS_RUN;
            default:                   state_d = CFI_SS_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= CFI_SS_RUN;
            viol_addr_q <= '0;
            mm_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (alarm) begin
                viol_addr_q <= ret_bad ? ev.target_i : ev.link_addr_i;
            end
            if (mm_inc && (mm_cnt_q != 16'hFFFF)) begin
                mm_cnt_q <= mm_cnt_q + 16'd1;
            end
        end
    end

    assign ev.ready_o     = (state_q == CFI_SS_RUN);
    assign violation_o    = (state_q == CFI_SS_ALARM);
    assign viol_addr_o    = viol_addr_q;
    assign count_o        = sel_cnt;
    assign mismatch_cnt_o = mm_cnt_q;

endmodule
